// File: rtl/cpu_pkg.sv
// Shared widths, reset constants and fetch FSM encoding for the 8-bit CPU.
package cpu_pkg;

  localparam int N_DATA   = 8;
  localparam int N_ADDR   = 8;
  localparam int RESET_PC = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async reset to RESET_PC, load has priority over inc.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int AW = N_ADDR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          load,
  input  logic [AW-1:0] d,
  output logic [AW-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= AW'(RESET_PC);
    end else if (load) begin
      q <= d;
    end else if (inc) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: req/ack ROM read into an instruction register
// presented downstream on a valid/ready handshake.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int n  = N_DATA,
  parameter int AW = N_ADDR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          halt,
  output logic [AW-1:0] rom_addr,
  output logic          rom_req,
  input  logic          rom_ack,
  input  logic [n-1:0]  rom_data,
  output logic [n-1:0]  Instruction,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          jump,
  input  logic [AW-1:0] jump_addr,
  output logic [AW-1:0] pc
);

  fetch_state_t  state, state_n;
  logic [AW-1:0] rom_addr_n;
  logic          rom_req_n;
  logic [n-1:0]  instr_n;
  logic          valid_n;
  logic          pc_inc;
  logic          pc_load;
  logic          go;

  assign go = en && !halt;

  pc_reg #(.AW(AW)) u_pc (
    .clk  (clk),
    .rst  (rst),
    .inc  (pc_inc),
    .load (pc_load),
    .d    (jump_addr),
    .q    (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rom_addr    <= '0;
      rom_req     <= 1'b0;
      Instruction <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_n;
      rom_addr    <= rom_addr_n;
      rom_req     <= rom_req_n;
      Instruction <= instr_n;
      instr_valid <= valid_n;
    end
  end

  always_comb begin
    state_n    = state;
    rom_addr_n = rom_addr;
    rom_req_n  = rom_req;
    instr_n    = Instruction;
    valid_n    = instr_valid;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          rom_addr_n = pc;
          rom_req_n  = 1'b1;
          state_n    = REQ;
        end
      end
      // A started read always completes; en/halt only gate the next start.
      REQ: begin
        if (rom_ack) begin
          instr_n   = rom_data;
          valid_n   = 1'b1;
          rom_req_n = 1'b0;
          pc_inc    = 1'b1;
          state_n   = HOLD;
        end
      end
      HOLD: begin
        if (instr_valid && instr_ready) begin
          valid_n = 1'b0;
          pc_load = jump;
          if (go) begin
            // pc already points past the consumed byte unless a jump redirects it
            rom_addr_n = jump ? jump_addr : pc;
            rom_req_n  = 1'b1;
            state_n    = REQ;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural ROM answering data = addr + 0x10.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, halt;
  logic [7:0] rom_addr;
  logic       rom_req;
  logic       rom_ack;
  logic [7:0] rom_data;
  logic [7:0] Instruction;
  logic       instr_valid;
  logic       instr_ready;
  logic       jump;
  logic [7:0] jump_addr;
  logic [7:0] pc;

  int checks = 0;
  int errors = 0;

  logic rom_on    = 1'b1;
  logic force_ack = 1'b0;
  int   ack_delay = 1;

  fetch_unit #(.n(8), .AW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .halt        (halt),
    .rom_addr    (rom_addr),
    .rom_req     (rom_req),
    .rom_ack     (rom_ack),
    .rom_data    (rom_data),
    .Instruction (Instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  // ROM: acks ack_delay cycles after it first sees rom_req
  initial begin
    int cnt;
    cnt      = 0;
    rom_ack  = 1'b0;
    rom_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rom_on && rom_req) begin
        if (cnt == ack_delay) begin
          rom_ack  = 1'b1;
          rom_data = rom_addr + 8'h10;
          cnt      = 0;
        end else begin
          rom_ack = 1'b0;
          cnt++;
        end
      end else begin
        rom_ack  = force_ack;
        rom_data = 8'hEE;
        cnt      = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; halt = 1'b0; instr_ready = 1'b0;
    jump = 1'b0; jump_addr = 8'h00;
    rom_on = 1'b1; force_ack = 1'b0; ack_delay = 1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input logic [7:0] exp_i, input logic [7:0] exp_pc, input string name);
    int k;
    k = 0;
    while (instr_valid !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: instr_valid=%b required 1", name, instr_valid);
    end else begin
      checks++;
      if (Instruction !== exp_i) begin
        errors++;
        $display("FAIL %s instr: got %h required %h", name, Instruction, exp_i);
      end
      checks++;
      if (pc !== exp_pc) begin
        errors++;
        $display("FAIL %s pc: got %h required %h", name, pc, exp_pc);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; halt = 1'b0; instr_ready = 1'b0;
    jump = 1'b0; jump_addr = 8'h00;
    tick();
    tick();
    checks++;
    if ({pc, rom_addr, rom_req, Instruction, instr_valid} !== 26'h0) begin
      errors++;
      $display("FAIL reset_state: pc=%h addr=%h req=%b instr=%h vld=%b required all 0",
               pc, rom_addr, rom_req, Instruction, instr_valid);
    end
    en = 1'b0;
    do_reset();
  endtask

  task automatic test_fetch();
    instr_ready = 1'b1;
    en = 1'b1;
    tick();
    checks++;
    if (rom_req !== 1'b1 || rom_addr !== 8'h00 || pc !== 8'h00) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h pc=%h required 1 00 00", rom_req, rom_addr, pc);
    end
    wait_valid(8'h10, 8'h01, "fetch0");
    tick();
    checks++;
    if (rom_req !== 1'b1 || rom_addr !== 8'h01 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL hs_to_req: req=%b addr=%h vld=%b required 1 01 0", rom_req, rom_addr, instr_valid);
    end
    wait_valid(8'h11, 8'h02, "fetch1");
    tick();
    wait_valid(8'h12, 8'h03, "fetch2");
    instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1;
    wait_valid(8'h10, 8'h01, "bp_fetch");
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (Instruction !== 8'h10 || instr_valid !== 1'b1 || rom_req !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: instr=%h vld=%b req=%b required 10 1 0",
                 i, Instruction, instr_valid, rom_req);
      end
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if (rom_req !== 1'b1 || rom_addr !== 8'h01) begin
      errors++;
      $display("FAIL bp_release: req=%b addr=%h required 1 01", rom_req, rom_addr);
    end
    wait_valid(8'h11, 8'h02, "bp_fetch1");
    tick();
    wait_valid(8'h12, 8'h03, "bp_fetch2");
    tick();
  endtask

  task automatic test_jump();
    wait_valid(8'h13, 8'h04, "jmp_src");
    jump = 1'b1; jump_addr = 8'h40;
    tick();
    jump = 1'b0; jump_addr = 8'h00;
    checks++;
    if (rom_req !== 1'b1 || rom_addr !== 8'h40 || pc !== 8'h40) begin
      errors++;
      $display("FAIL jump_target: req=%b addr=%h pc=%h required 1 40 40", rom_req, rom_addr, pc);
    end
    wait_valid(8'h50, 8'h41, "jmp_fetch");
  endtask

  task automatic test_wrap();
    jump = 1'b1; jump_addr = 8'hFF;
    tick();
    jump = 1'b0;
    checks++;
    if (rom_addr !== 8'hFF || pc !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_jump: addr=%h pc=%h required ff ff", rom_addr, pc);
    end
    wait_valid(8'h0F, 8'h00, "wrap_fetch");
    tick();
    checks++;
    if (rom_req !== 1'b1 || rom_addr !== 8'h00) begin
      errors++;
      $display("FAIL wrap_next: req=%b addr=%h required 1 00", rom_req, rom_addr);
    end
    wait_valid(8'h10, 8'h01, "wrap_fetch1");
    instr_ready = 1'b0;
  endtask

  task automatic test_halt_slow();
    ack_delay = 4;
    instr_ready = 1'b1;
    tick();
    halt = 1'b1;
    checks++;
    if (rom_req !== 1'b1 || rom_addr !== 8'h01) begin
      errors++;
      $display("FAIL halt_req: req=%b addr=%h required 1 01", rom_req, rom_addr);
    end
    wait_valid(8'h11, 8'h02, "halt_fetch");
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rom_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 8'h02) begin
        errors++;
        $display("FAIL halt_idle%0d: req=%b vld=%b pc=%h required 0 0 02",
                 i, rom_req, instr_valid, pc);
      end
    end
    halt = 1'b0;
    tick();
    checks++;
    if (rom_req !== 1'b1 || rom_addr !== 8'h02) begin
      errors++;
      $display("FAIL halt_resume: req=%b addr=%h required 1 02", rom_req, rom_addr);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    rom_on = 1'b0;
    force_ack = 1'b1;
    en = 1'b0;
    #1;
    checks++;
    if (rom_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 8'h00 || Instruction !== 8'h00) begin
      errors++;
      $display("FAIL async_rst: req=%b vld=%b pc=%h instr=%h required 0 0 00 00",
               rom_req, instr_valid, pc, Instruction);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b0 || pc !== 8'h00 || rom_req !== 1'b0) begin
        errors++;
        $display("FAIL late_ack%0d: vld=%b pc=%h req=%b required 0 00 0",
                 i, instr_valid, pc, rom_req);
      end
    end
    force_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_backpressure();
    test_jump();
    test_wrap();
    test_halt_slow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 8-bit microprocessor. It sits directly upstream of the decode/immediate-extract stage.
- Holds the program counter and issues a req/ack read to program ROM. It latches the returned byte into an instruction register and presents it downstream on a valid/ready handshake.
- Its `Instruction` output feeds the decoder and immediate extractor unchanged. It accepts jump targets from the decoder.

Parameters:
- n, 8, instruction/data width in bits.
- AW, 8, program-address width in bits; PC wraps modulo 2^AW.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  fetch enable; when low, no new ROM request is started.
- halt  input  1  stop request; same effect as en=0 for starting fetches.
- rom_addr  output  AW  ROM address; equals PC latched at request start.
- rom_req  output  1  ROM read request.
- rom_ack  input  1  ROM data-valid strobe; rom_data is valid in the same cycle.
- rom_data  input  n  ROM read data.
- Instruction  output  n  registered instruction to the decoder.
- instr_valid  output  1  Instruction holds an unconsumed fetched byte.
- instr_ready  input  1  decoder accepts Instruction this cycle.
- jump  input  1  load PC with jump_addr; sampled only on handshake.
- jump_addr  input  AW  jump target.
- pc  output  AW  current program counter (next address to fetch).

Behaviour:
- Reset (async, rst=1): pc=0, rom_addr=0, rom_req=0, Instruction=0, instr_valid=0, state=IDLE. Any outstanding ROM transaction is abandoned.
- FSM states: IDLE, REQ, HOLD. Only the registered outputs above leave the block.
- IDLE:
  - If en=1 and halt=0: rom_addr<=pc, rom_req<=1, go to REQ.
  - Otherwise stay in IDLE; outputs hold.
- REQ:
  - rom_req stays 1 and rom_addr stays stable until rom_ack=1.
  - On rom_ack: Instruction<=rom_data, instr_valid<=1, rom_req<=0, pc<=pc+1 mod 2^AW (0xFF -> 0x00 at AW=8), go to HOLD.
  - en/halt changes during REQ do not abort the transaction; it always completes.
- HOLD:
  - Instruction and instr_valid stay stable until instr_ready=1.
  - On handshake (instr_valid & instr_ready):
    - instr_valid<=0.
    - If jump=1, pc<=jump_addr; jump overrides the increment already applied.
    - If en=1 and halt=0: rom_addr<=(jump ? jump_addr : pc), rom_req<=1, go to REQ.
    - Otherwise go to IDLE.
- Ignored inputs:
  - rom_ack outside REQ is ignored.
  - jump outside a HOLD handshake cycle is ignored.
- Latency:
  - rom_ack in cycle t gives instr_valid=1 in cycle t+1.
  - A handshake in cycle k gives rom_req=1 in cycle k+1.
  - With zero-wait ROM and instr_ready tied high, throughput is one instruction per 2 cycles.
- Only one transaction is outstanding at a time; there is no buffering beyond the instruction register.
- pc output always reflects the register value, including during REQ.

Decomposition:
- Shared package (cpu_pkg):
  - Width constants N_DATA=8, N_ADDR=8.
  - fetch_state_t enum {IDLE, REQ, HOLD} with 2-bit encoding.
  - RESET_PC=0.
- Sub-module pc_reg:
  - AW-bit register with async active-high reset to RESET_PC.
  - Priority inc/load inputs: load wins over inc.
  - Instantiated once in fetch_unit.

Test Plan:
- Reset then en=1, ROM acks 1 cycle after each req with data=addr+0x10, instr_ready=1:
  - Instructions 0x10, 0x11, 0x12 appear in order.
  - pc reads 1, 2, 3 after each ack.
- Backpressure:
  - Hold instr_ready=0 for 5 cycles after a fetch; Instruction stays 0x10 and instr_valid stays 1.
  - No new rom_req is issued.
  - Raise instr_ready; rom_req asserts the next cycle with rom_addr=0x01.
- Jump:
  - At the handshake of the instruction from address 0x03, drive jump=1, jump_addr=0x40.
  - Next rom_addr=0x40, pc=0x40, and the following pc=0x41.
- Wrap-around:
  - Jump to 0xFF; after its ack, pc=0x00 and the next rom_addr=0x00.
- Halt/enable and slow ROM:
  - Assert halt during REQ with a 4-cycle ack delay; the fetch completes and instr_valid rises.
  - After the handshake, FSM is IDLE and rom_req=0.
  - Deassert halt; fetching resumes at the current pc.
- Async reset mid-operation:
  - Assert rst in REQ between clock edges; rom_req, instr_valid and pc drop to 0 immediately.
  - A late rom_ack after reset is ignored.
